step_clock_gen: RTL and testbench



---
 rtl/step_clock_gen.sv | 155 +++++++++++++++
 tb/tb_step_clock_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/step_clock_gen.sv
// Step clock source for the lab counter chain: debounced push-button pulses in
// manual mode, or a free-running square wave in auto mode. All outputs registered.
module step_clock_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_W         = 4,
  parameter int AUTO_HALF       = 50_000_000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic iKey,
  input  logic iAuto,
  output logic oCLK,
  output logic oKeyLevel,
  output logic oAuto
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW_W  = $clog2(PULSE_W + 1);
  localparam int DIV_W = $clog2(AUTO_HALF + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_HALF - 1);

  typedef enum logic [1:0] {
    MAN_IDLE  = 2'd0,
    MAN_PULSE = 2'd1,
    AUTO      = 2'd2
  } state_t;

  logic             key_meta_r;
  logic             key_sync_r;
  logic             auto_meta_r;
  logic             auto_sync_r;
  logic             key_level_r;
  logic             key_prev_r;
  logic [DB_W-1:0]  db_cnt_r;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PW_W-1:0]  pcnt_r;
  logic [PW_W-1:0]  pcnt_nxt_s;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             oclk_r;
  logic             oclk_nxt_s;

  logic             step_req_s;
  logic             mode_chg_s;

  // Step request is a registered rise of the debounced level; the mode changes
  // on the edge where the second synchronizer stage takes a new value.
  assign step_req_s = key_level_r & ~key_prev_r;
  assign mode_chg_s = auto_meta_r ^ auto_sync_r;

  // Input synchronizers and key debouncer.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r  <= 1'b0;
      key_sync_r  <= 1'b0;
      auto_meta_r <= 1'b0;
      auto_sync_r <= 1'b0;
      key_level_r <= 1'b0;
      key_prev_r  <= 1'b0;
      db_cnt_r    <= {DB_W{1'b0}};
    end else begin
      key_meta_r  <= iKey;
      key_sync_r  <= key_meta_r;
      auto_meta_r <= iAuto;
      auto_sync_r <= auto_meta_r;
      key_prev_r  <= key_level_r;
      if (key_sync_r != key_level_r) begin
        if (db_cnt_r == DB_LAST) begin
          key_level_r <= ~key_level_r;
          db_cnt_r    <= {DB_W{1'b0}};
        end else begin
          db_cnt_r    <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  // Output state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MAN_IDLE;
      pcnt_r  <= {PW_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      oclk_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
      div_r   <= div_nxt_s;
      oclk_r  <= oclk_nxt_s;
    end
  end

  // Next-state logic; a mode change overrides everything and only ever drops oCLK.
  always_comb begin
    state_nxt_s = state_r;
    pcnt_nxt_s  = pcnt_r;
    div_nxt_s   = div_r;
    oclk_nxt_s  = oclk_r;
    if (mode_chg_s) begin
      pcnt_nxt_s  = {PW_W{1'b0}};
      div_nxt_s   = {DIV_W{1'b0}};
      oclk_nxt_s  = 1'b0;
      state_nxt_s = auto_meta_r ? AUTO : MAN_IDLE;
    end else begin
      case (state_r)
        MAN_IDLE: begin
          oclk_nxt_s = 1'b0;
          if (step_req_s) begin
            state_nxt_s = MAN_PULSE;
            pcnt_nxt_s  = {PW_W{1'b0}};
            oclk_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = MAN_IDLE;
          end
        end
        MAN_PULSE: begin
          if (pcnt_r == PW_LAST) begin
            state_nxt_s = MAN_IDLE;
            pcnt_nxt_s  = {PW_W{1'b0}};
            oclk_nxt_s  = 1'b0;
          end else begin
            pcnt_nxt_s  = pcnt_r + PW_W'(1);
            oclk_nxt_s  = 1'b1;
          end
        end
        AUTO: begin
          if (div_r == DIV_LAST) begin
            div_nxt_s  = {DIV_W{1'b0}};
            oclk_nxt_s = ~oclk_r;
          end else begin
            div_nxt_s  = div_r + DIV_W'(1);
          end
        end
        default: begin
          state_nxt_s = MAN_IDLE;
          pcnt_nxt_s  = {PW_W{1'b0}};
          div_nxt_s   = {DIV_W{1'b0}};
          oclk_nxt_s  = 1'b0;
        end
      endcase
    end
  end

  assign oCLK      = oclk_r;
  assign oKeyLevel = key_level_r;
  assign oAuto     = auto_sync_r;

endmodule

// File: tb/tb_step_clock_gen.sv
// Randomized bench for step_clock_gen: an event-time reference model feeds an
// expectation queue that a negedge monitor drains against the DUT outputs.
module tb_step_clock_gen;

  localparam int DB = 8;
  localparam int PW = 3;
  localparam int AH = 5;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  logic iKey  = 1'b0;
  logic iAuto = 1'b0;
  logic oCLK;
  logic oKeyLevel;
  logic oAuto;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];
  logic [2:0] mon_e;

  // Reference model state: absolute edge index, pipeline samples, debounce run
  // length, auto-mode start edge and manual pulse start edge.
  int t        = 0;
  bit m_kmeta  = 1'b0;
  bit m_ksync  = 1'b0;
  bit m_ameta  = 1'b0;
  bit m_async  = 1'b0;
  bit m_lvl    = 1'b0;
  bit m_lvl_d  = 1'b0;
  bit m_oclk   = 1'b0;
  bit m_pv     = 1'b0;
  int m_run    = 0;
  int m_mstart = 0;
  int m_ps     = 0;
  bit new_lvl;
  bit new_auto;
  bit req;

  step_clock_gen #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_W        (PW),
    .AUTO_HALF      (AH)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .iKey     (iKey),
    .iAuto    (iAuto),
    .oCLK     (oCLK),
    .oKeyLevel(oKeyLevel),
    .oAuto    (oAuto)
  );

  always #5 CLK = ~CLK;

  // Reference model: one expectation per rising edge.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_kmeta = 1'b0; m_ksync = 1'b0; m_ameta = 1'b0; m_async = 1'b0;
      m_lvl = 1'b0; m_lvl_d = 1'b0; m_oclk = 1'b0; m_pv = 1'b0;
      m_run = 0; m_mstart = 0; m_ps = 0;
      exp_q.delete();
    end else begin
      t++;
      new_lvl = m_lvl;
      if (m_ksync != m_lvl) begin
        m_run++;
        if (m_run == DB) begin
          new_lvl = !m_lvl;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      req      = m_lvl && !m_lvl_d;
      new_auto = m_ameta;
      if (new_auto != m_async) begin
        m_mstart = t;
        m_pv     = 1'b0;
        m_oclk   = 1'b0;
      end else if (new_auto) begin
        m_oclk = (((t - m_mstart) / AH) % 2) == 1;
      end else begin
        if (req && !(m_pv && t <= m_ps + PW)) begin
          m_ps = t;
          m_pv = 1'b1;
        end
        m_oclk = m_pv && (t < m_ps + PW);
      end
      m_lvl_d = m_lvl;
      m_lvl   = new_lvl;
      m_ksync = m_kmeta;
      m_kmeta = iKey;
      m_async = m_ameta;
      m_ameta = iAuto;
      exp_q.push_back({m_oclk, m_lvl, m_async});
    end
  end

  // Monitor: outputs must be zero whenever reset is low, else match the model.
  always @(negedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      vectors++;
      if ({oCLK, oKeyLevel, oAuto} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_outputs: {oCLK,oKeyLevel,oAuto} got %b want 000", {oCLK, oKeyLevel, oAuto});
      end
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if ({oCLK, oKeyLevel, oAuto} !== mon_e) begin
        miscompares++;
        $display("FAIL outputs edge %0d: {oCLK,oKeyLevel,oAuto} got %b want %b", t, {oCLK, oKeyLevel, oAuto}, mon_e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_model_high();
    for (int i = 0; i < 60; i++) begin
      if (m_oclk) return;
      @(negedge CLK);
    end
    $display("FAIL wait_oclk_high: model oCLK got 0 want 1 within 60 cycles");
    $fatal(1, "timeout");
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    #2 rst_n = 1'b0;
    cyc(3);
    iKey  = 1'b0;
    iAuto = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(100);

    for (int i = 0; i < 3; i++) begin
      iKey = 1'b1; cyc(DB + PW + 5 + int'($urandom_range(0, 10)));
      iKey = 1'b0; cyc(DB + 5 + int'($urandom_range(0, 10)));
    end

    for (int i = 0; i < 10; i++) begin
      iKey = ~iKey; cyc(3);
    end
    iKey = 1'b1; cyc(30);
    iKey = 1'b0; cyc(20);

    for (int i = 0; i < 40; i++) begin
      iKey = 1'($urandom_range(0, 1)); cyc(int'($urandom_range(1, 14)));
    end
    iKey = 1'b0; cyc(20);

    iAuto = 1'b1; cyc(17);
    iKey  = 1'b1; cyc(25);
    iKey  = 1'b0; cyc(25);

    wait_model_high();
    iAuto = 1'b0; cyc(10);
    iKey  = 1'b1; cyc(20);
    iKey  = 1'b0; cyc(20);

    iKey = 1'b1; cyc(200);
    iKey = 1'b0; cyc(20);
    iKey = 1'b1; cyc(20);
    iKey = 1'b0; cyc(20);

    iKey = 1'b1;
    wait_model_high();
    mid_reset();
    cyc(20);
    iAuto = 1'b1; cyc(3);
    wait_model_high();
    mid_reset();
    cyc(100);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) iAuto = ~iAuto;
      iKey = 1'($urandom_range(0, 1));
      cyc(int'($urandom_range(1, 14)));
    end
    iKey = 1'b0; iAuto = 1'b0;
    cyc(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
